// File: rtl/rop_rmw_ctrl.sv
// Read-modify-write controller for the ROP colour buffer.
// One fragment in flight: accept, read destination pixel, present src/dst to
// the external blend unit for one cycle, then write the merged pixel back under
// the per-channel write mask.
// Optional build macro: ROP_REPLACE_BYPASS_EN -- mode 0 (replace) skips the
// destination read and merges against an all-zero destination.
module rop_rmw_ctrl #(
  parameter int W  = 8,
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frag_valid,
  output logic            frag_ready,
  input  logic [AW-1:0]   frag_addr,
  input  logic [4*W-1:0]  frag_rgba,
  input  logic [3:0]      frag_mode,
  input  logic [3:0]      frag_wmask,
  output logic            mem_rd_valid,
  input  logic            mem_rd_ready,
  output logic [AW-1:0]   mem_rd_addr,
  input  logic            mem_rdata_valid,
  input  logic [4*W-1:0]  mem_rdata,
  output logic [4*W-1:0]  blend_src,
  output logic [4*W-1:0]  blend_dst,
  output logic [3:0]      blend_mode,
  input  logic [3*W-1:0]  blend_rgb,
  output logic            mem_wr_valid,
  input  logic            mem_wr_ready,
  output logic [AW-1:0]   mem_wr_addr,
  output logic [4*W-1:0]  mem_wr_data,
  output logic [3:0]      mem_wr_be,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    BLEND   = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  state_t          state_r;
  logic            idle_r;
  logic            busy_r;
  logic            rd_valid_r;
  logic            wr_valid_r;
  logic [AW-1:0]   addr_r;
  logic [4*W-1:0]  src_r;
  logic [4*W-1:0]  dst_r;
  logic [4*W-1:0]  wr_data_r;
  logic [3:0]      mode_r;
  logic [3:0]      wmask_r;
  logic            accept_s;
  logic            bypass_s;
  logic [4*W-1:0]  merge_s;

  // Per-channel merge: RGB take the blend result when enabled, alpha takes the
  // source alpha when enabled; disabled channels keep the destination value.
  function automatic logic [4*W-1:0] merge_px(
    input logic [3:0]     wmask,
    input logic [4*W-1:0] src,
    input logic [4*W-1:0] dst,
    input logic [3*W-1:0] rgb
  );
    logic [4*W-1:0] px;
    px[4*W-1:3*W] = wmask[3] ? rgb[3*W-1:2*W] : dst[4*W-1:3*W];
    px[3*W-1:2*W] = wmask[2] ? rgb[2*W-1:W]   : dst[3*W-1:2*W];
    px[2*W-1:W]   = wmask[1] ? rgb[W-1:0]     : dst[2*W-1:W];
    px[W-1:0]     = wmask[0] ? src[W-1:0]     : dst[W-1:0];
    return px;
  endfunction

  assign accept_s = frag_valid & frag_ready;
  assign merge_s  = merge_px(wmask_r, src_r, dst_r, blend_rgb);

`ifdef ROP_REPLACE_BYPASS_EN
  assign bypass_s = (frag_mode == 4'd0);
`else
  assign bypass_s = 1'b0;
`endif

  // Main FSM: sequences the fragment and drives every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idle_r     <= 1'b1;
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      wr_valid_r <= 1'b0;
      addr_r     <= {AW{1'b0}};
      src_r      <= {(4*W){1'b0}};
      dst_r      <= {(4*W){1'b0}};
      wr_data_r  <= {(4*W){1'b0}};
      mode_r     <= 4'd0;
      wmask_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r  <= frag_addr;
            src_r   <= frag_rgba;
            mode_r  <= frag_mode;
            wmask_r <= frag_wmask;
            idle_r  <= 1'b0;
            busy_r  <= 1'b1;
            if (bypass_s) begin
              dst_r   <= {(4*W){1'b0}};
              state_r <= BLEND;
            end else begin
              rd_valid_r <= 1'b1;
              state_r    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mem_rd_ready) begin
            rd_valid_r <= 1'b0;
            state_r    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rdata_valid) begin
            dst_r   <= mem_rdata;
            state_r <= BLEND;
          end
        end
        BLEND: begin
          wr_data_r <= merge_s;
          if (wmask_r == 4'd0) begin
            idle_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            wr_valid_r <= 1'b1;
            state_r    <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem_wr_ready) begin
            wr_valid_r <= 1'b0;
            idle_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          rd_valid_r <= 1'b0;
          wr_valid_r <= 1'b0;
          idle_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by rst_n so it stays low for the whole reset pulse.
  assign frag_ready   = idle_r & rst_n;
  assign busy         = busy_r;
  assign mem_rd_valid = rd_valid_r;
  assign mem_rd_addr  = addr_r;
  assign mem_wr_valid = wr_valid_r;
  assign mem_wr_addr  = addr_r;
  assign mem_wr_data  = wr_data_r;
  assign mem_wr_be    = wmask_r;
  assign blend_src    = src_r;
  assign blend_dst    = dst_r;
  assign blend_mode   = mode_r;

endmodule

// File: tb/tb_rop_rmw_ctrl.sv
// Self-checking bench for rop_rmw_ctrl: directed scenarios followed by
// randomized fragments with random memory stalls, checked against a pixel-level
// reference model (sparse colour memory + blend function + channel merge).
module tb_rop_rmw_ctrl;
  localparam int W  = 8;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frag_valid;
  logic            frag_ready;
  logic [AW-1:0]   frag_addr;
  logic [4*W-1:0]  frag_rgba;
  logic [3:0]      frag_mode;
  logic [3:0]      frag_wmask;
  logic            mem_rd_valid;
  logic            mem_rd_ready;
  logic [AW-1:0]   mem_rd_addr;
  logic            mem_rdata_valid;
  logic [4*W-1:0]  mem_rdata;
  logic [4*W-1:0]  blend_src;
  logic [4*W-1:0]  blend_dst;
  logic [3:0]      blend_mode;
  logic [3*W-1:0]  blend_rgb;
  logic            mem_wr_valid;
  logic            mem_wr_ready;
  logic [AW-1:0]   mem_wr_addr;
  logic [4*W-1:0]  mem_wr_data;
  logic [3:0]      mem_wr_be;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int rd_hs = 0;
  int wr_hs = 0;
  int exp_reads = 0;
  int exp_writes = 0;
  logic [31:0] mem [logic [15:0]];
  logic [31:0] last_dst = 32'h0;

  rop_rmw_ctrl #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_addr(frag_addr),
    .frag_rgba(frag_rgba), .frag_mode(frag_mode), .frag_wmask(frag_wmask),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .blend_src(blend_src), .blend_dst(blend_dst), .blend_mode(blend_mode),
    .blend_rgb(blend_rgb),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural blend unit: 0 replace, 1 average, 2 saturating add, else xor.
  function automatic logic [23:0] blend_fn(input logic [3:0] m, input logic [31:0] s,
                                           input logic [31:0] d);
    logic [23:0] res;
    logic [7:0]  sc, dc, r;
    logic [8:0]  sum;
    res = 24'h0;
    for (int c = 0; c < 3; c++) begin
      sc  = s[31-8*c -: 8];
      dc  = d[31-8*c -: 8];
      sum = {1'b0, sc} + {1'b0, dc};
      case (m)
        4'd0:    r = sc;
        4'd1:    r = sum[8:1];
        4'd2:    r = sum[8] ? 8'hFF : sum[7:0];
        default: r = sc ^ dc;
      endcase
      res[23-8*c -: 8] = r;
    end
    return res;
  endfunction

  assign blend_rgb = blend_fn(blend_mode, blend_src, blend_dst);

  // Expected pixel written back: channel list {R,G,B,A}, wmask bit 3 = R.
  function automatic logic [31:0] expect_px(input logic [3:0] wm, input logic [31:0] s,
                                            input logic [31:0] d, input logic [23:0] rgb);
    logic [7:0] out_b [4];
    logic [31:0] px;
    for (int i = 0; i < 4; i++) begin
      if (!wm[3-i])   out_b[i] = d[31-8*i -: 8];
      else if (i < 3) out_b[i] = rgb[23-8*i -: 8];
      else            out_b[i] = s[7:0];
    end
    px = {out_b[0], out_b[1], out_b[2], out_b[3]};
    return px;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {63'd0, frag_ready}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_rdv"}, {63'd0, mem_rd_valid}, 64'd0);
    check({tag, "_rda"}, {48'd0, mem_rd_addr}, 64'd0);
    check({tag, "_wrv"}, {63'd0, mem_wr_valid}, 64'd0);
    check({tag, "_wra"}, {48'd0, mem_wr_addr}, 64'd0);
    check({tag, "_wrd"}, {32'd0, mem_wr_data}, 64'd0);
    check({tag, "_be"}, {60'd0, mem_wr_be}, 64'd0);
    check({tag, "_bsrc"}, {32'd0, blend_src}, 64'd0);
    check({tag, "_bdst"}, {32'd0, blend_dst}, 64'd0);
    check({tag, "_bmode"}, {60'd0, blend_mode}, 64'd0);
  endtask

  // Handshake counters seen at the memory side.
  always @(posedge clk) begin
    if (mem_rd_valid && mem_rd_ready) rd_hs <= rd_hs + 1;
    if (mem_wr_valid && mem_wr_ready) wr_hs <= wr_hs + 1;
  end

  // One fragment end to end; called and returns at a negedge with the DUT idle.
  task automatic do_frag(input logic [15:0] a, input logic [31:0] s, input logic [3:0] m,
                         input logic [3:0] wm, input int rd_stall, input int rdly,
                         input int wr_stall, input bit chk_lat);
    logic [31:0] d;
    logic [31:0] exp_px;
    bit byp;
    byp = 1'b0;
`ifdef ROP_REPLACE_BYPASS_EN
    byp = (m == 4'd0);
`endif
    if (!mem.exists(a)) mem[a] = $urandom;
    d = byp ? 32'h0 : mem[a];
    exp_px = expect_px(wm, s, d, blend_fn(m, s, d));

    check("ready_idle", {63'd0, frag_ready}, 64'd1);
    frag_valid = 1'b1; frag_addr = a; frag_rgba = s; frag_mode = m; frag_wmask = wm;
    k = 0;
    step();
    frag_valid = 1'b0; frag_addr = 16'($urandom); frag_rgba = $urandom;
    frag_mode = 4'($urandom); frag_wmask = 4'($urandom);
    check("busy", {63'd0, busy}, 64'd1);
    check("ready_busy", {63'd0, frag_ready}, 64'd0);
    if (!byp) begin
      exp_reads++;
      check("rd_valid", {63'd0, mem_rd_valid}, 64'd1);
      check("rd_addr", {48'd0, mem_rd_addr}, {48'd0, a});
      for (int i = 0; i < rd_stall; i++) begin
        step();
        check("rd_hold_v", {63'd0, mem_rd_valid}, 64'd1);
        check("rd_hold_a", {48'd0, mem_rd_addr}, {48'd0, a});
      end
      mem_rd_ready = 1'b1;
      step();
      mem_rd_ready = 1'b0;
      check("rd_drop", {63'd0, mem_rd_valid}, 64'd0);
      for (int i = 0; i < rdly; i++) step();
      mem_rdata_valid = 1'b1; mem_rdata = d;
      step();
      mem_rdata_valid = 1'b0; mem_rdata = $urandom;
    end else begin
      check("byp_no_rd", {63'd0, mem_rd_valid}, 64'd0);
    end
    // Blend cycle
    check("blend_src", {32'd0, blend_src}, {32'd0, s});
    check("blend_dst", {32'd0, blend_dst}, {32'd0, d});
    check("blend_mode", {60'd0, blend_mode}, {60'd0, m});
    last_dst = d;
    step();
    if (wm != 4'd0) begin
      exp_writes++;
      check("wr_valid", {63'd0, mem_wr_valid}, 64'd1);
      check("wr_addr", {48'd0, mem_wr_addr}, {48'd0, a});
      check("wr_data", {32'd0, mem_wr_data}, {32'd0, exp_px});
      check("wr_be", {60'd0, mem_wr_be}, {60'd0, wm});
      if (chk_lat) check("lat_wr", 64'(k), byp ? 64'd2 : 64'd4);
      for (int i = 0; i < wr_stall; i++) begin
        step();
        check("wr_hold_v", {63'd0, mem_wr_valid}, 64'd1);
        check("wr_hold_a", {48'd0, mem_wr_addr}, {48'd0, a});
        check("wr_hold_d", {32'd0, mem_wr_data}, {32'd0, exp_px});
        check("wr_hold_be", {60'd0, mem_wr_be}, {60'd0, wm});
      end
      mem_wr_ready = 1'b1;
      step();
      mem_wr_ready = 1'b0;
      mem[a] = exp_px;
    end else begin
      check("no_wr", {63'd0, mem_wr_valid}, 64'd0);
    end
    check("wr_drop", {63'd0, mem_wr_valid}, 64'd0);
    check("ready_back", {63'd0, frag_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);
    if (chk_lat) check("lat_rdy", 64'(k), byp ? 64'd3 : ((wm != 4'd0) ? 64'd5 : 64'd4));
  endtask

  // A stray read-data strobe while idle must not touch the destination register.
  task automatic spurious();
    mem_rdata_valid = 1'b1; mem_rdata = $urandom;
    step();
    mem_rdata_valid = 1'b0;
    step();
    check("spur_dst", {32'd0, blend_dst}, {32'd0, last_dst});
    check("spur_busy", {63'd0, busy}, 64'd0);
    check("spur_rdv", {63'd0, mem_rd_valid}, 64'd0);
  endtask

  // Reset pulsed while waiting for read data; late data must be ignored.
  task automatic reset_mid();
    check("rst_ready", {63'd0, frag_ready}, 64'd1);
    frag_valid = 1'b1; frag_addr = 16'h0200; frag_rgba = 32'h12345678;
    frag_mode = 4'd1; frag_wmask = 4'hF;
    step();
    frag_valid = 1'b0;
    exp_reads++;
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    check_all_zero("midrst2");
    rst_n = 1'b1;
    step();
    step();
    mem_rdata_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rdata_valid = 1'b0;
    last_dst = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("rst_no_wr", {63'd0, mem_wr_valid}, 64'd0);
      step();
    end
    check("rst_idle", {63'd0, busy}, 64'd0);
    check("rst_bdst", {32'd0, blend_dst}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    frag_valid = 1'b0; frag_addr = 16'h0; frag_rgba = 32'h0; frag_mode = 4'h0;
    frag_wmask = 4'h0; mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = 32'h0;
    mem_wr_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Directed scenarios
    mem[16'h0100] = 32'h0000FFFF;
    do_frag(16'h0100, 32'hFF000080, 4'd1, 4'hF, 0, 0, 0, 1'b1);
    mem[16'h0101] = 32'h0000FFFF;
    do_frag(16'h0101, 32'hFF000080, 4'd1, 4'b1000, 0, 0, 0, 1'b1);
    do_frag(16'h0102, 32'hFF000080, 4'd1, 4'h0, 0, 0, 0, 1'b1);
    do_frag(16'hFFFF, 32'hA5C3E1F0, 4'd2, 4'hF, 3, 0, 5, 1'b0);
    spurious();
    reset_mid();
    do_frag(16'h0200, 32'h12345678, 4'd1, 4'hF, 0, 0, 0, 1'b1);
    do_frag(16'h0300, 32'h11223344, 4'd0, 4'hF, 0, 0, 0, 1'b1);
    do_frag(16'h0301, 32'h11223344, 4'd0, 4'b0101, 0, 1, 0, 1'b0);

    // Randomized fragments with random stalls
    for (int n = 0; n < 150; n++) begin
      do_frag(16'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 3)),
              4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 3) == 0) spurious();
    end

    step();
    check("rd_count", 64'(rd_hs), 64'(exp_reads));
    check("wr_count", 64'(wr_hs), 64'(exp_writes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
